// File: rtl/fast_control_sched.sv
// fast_control_sched: clk_bx fast-control word generator (orbit/BCR, spaced L1A queue, sticky commands, Hamming(8,4) link encoding).
// Define FC_CMD_COUNTERS_EN to add saturating per-bit issue counters on cmd_count.
module fast_control_sched #(
    parameter int NIBBLES = 2,
    parameter int NUM_CMD = 3,
    parameter int L1A_QDEPTH = 8,
    parameter logic [NUM_CMD-1:0] DEFER_MASK = 'b110
) (
    input  logic                   clk_bx,
    input  logic                   reset_n,
    input  logic [11:0]            orb_length,
    input  logic                   bcr_enable,
    input  logic [7:0]             l1a_min_gap,
    input  logic [NUM_CMD-1:0]     cmd_req,
    input  logic [4*NIBBLES-1:0]   aux_bits,
    output logic [4*NIBBLES-1:0]   fc_word,
    output logic [8*NIBBLES-1:0]   fc_stream_enc,
    output logic [11:0]            bx_counter,
    output logic [7:0]             l1a_pending,
    output logic                   l1a_overflow
`ifdef FC_CMD_COUNTERS_EN
   ,output logic [32*(NUM_CMD+1)-1:0] cmd_count
`endif
);
    localparam int W = 4 * NIBBLES;
    localparam int NP = NUM_CMD > 1 ? NUM_CMD : 2;
    localparam logic [7:0] QMAX = 8'(L1A_QDEPTH);

    function automatic logic [7:0] hamming84_enc(input logic [3:0] d);
        logic [6:0] c;
        c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
        return {^c, c};
    endfunction

    logic [12:0]   bx_inc;
    logic          bx_wrap;
    logic          bcr;
    logic          l1a_issue;
    logic [7:0]    gap_eff;
    logic [7:0]    since_l1a;
    logic [NP-1:1] cmd_pend;
    logic [NP-1:1] cmd_issue;
    logic [W-1:0]  word_next;
    logic [2*W-1:0] enc_next;

    assign bx_inc = {1'b0, bx_counter} + 13'd1;
    assign bx_wrap = orb_length == '0 ? bx_counter == 12'hfff : bx_inc >= {1'b0, orb_length};
    assign bcr = bx_counter == '0 && bcr_enable;
    assign gap_eff = l1a_min_gap == '0 ? 8'd1 : l1a_min_gap;
    // since_l1a is 0 only until the first issue after reset, which therefore ignores spacing
    assign l1a_issue = l1a_pending != '0 && (since_l1a == '0 || since_l1a >= gap_eff);

    always_comb begin
        cmd_issue = '0;
        enc_next = '0;
        word_next = aux_bits;
        word_next[0] = bcr;
        word_next[1] = l1a_issue;
        for (int k = 1; k < NUM_CMD; k++) begin
            cmd_issue[k] = cmd_pend[k] && !(DEFER_MASK[k] && bcr);
            word_next[k+1] = cmd_issue[k];
        end
        for (int n = 0; n < NIBBLES; n++)
            enc_next[8*n +: 8] = hamming84_enc(fc_word[4*n +: 4]);
    end

    always_ff @(posedge clk_bx) begin
        if (!reset_n) begin
            bx_counter <= '0;
            fc_word <= '0;
            fc_stream_enc <= '0;
            l1a_pending <= '0;
            l1a_overflow <= 1'b0;
            since_l1a <= '0;
            cmd_pend <= '0;
        end else begin
            bx_counter <= bx_wrap ? '0 : bx_inc[11:0];
            fc_word <= word_next;
            fc_stream_enc <= enc_next;
            if (cmd_req[0] && !l1a_issue) begin
                if (l1a_pending == QMAX)
                    l1a_overflow <= 1'b1;
                else
                    l1a_pending <= l1a_pending + 8'd1;
            end else if (l1a_issue && !cmd_req[0]) begin
                l1a_pending <= l1a_pending - 8'd1;
            end
            since_l1a <= l1a_issue ? 8'd1 : (since_l1a == '0 || since_l1a == 8'hff) ? since_l1a : since_l1a + 8'd1;
            for (int k = 1; k < NUM_CMD; k++)
                cmd_pend[k] <= cmd_req[k] || (cmd_pend[k] && !cmd_issue[k]);
        end
    end

`ifdef FC_CMD_COUNTERS_EN
    always_ff @(posedge clk_bx) begin
        for (int j = 0; j <= NUM_CMD; j++)
            if (!reset_n)
                cmd_count[32*j +: 32] <= '0;
            else if (word_next[j] && cmd_count[32*j +: 32] != '1)
                cmd_count[32*j +: 32] <= cmd_count[32*j +: 32] + 32'd1;
    end
`endif

endmodule
